// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full_subtractor cell processes one bit per clock, LSB first.
// A registered borrow flop closes the loop from the cell's b_out back to its b_in.

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic b_out
);

    assign diff  = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             cell_diff, cell_bout;
    logic             load, last_bit;

    full_subtractor u_cell (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .b_in  (borrow),
        .diff  (cell_diff),
        .b_out (cell_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // start is honoured in DONE too, so back-to-back operations lose no cycle
    always_comb begin
        next_state = state;
        load       = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last_bit   = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cnt        <= '0;
            borrow     <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {cell_diff, res_sr[WIDTH-1:1]};
            borrow <= cell_bout;
            cnt    <= cnt + 1'b1;
            // the final bit goes straight to the outputs, not via res_sr
            if (last_bit) begin
                diff       <= {cell_diff, res_sr[WIDTH-1:1]};
                borrow_out <= cell_bout;
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor: 8-bit instance for timing and corner
// cases, plus a 4-bit instance checked exhaustively against a - b.

module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done;
    logic [7:0] diff;
    logic       borrow_out;

    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4;
    logic [3:0] diff4;
    logic       borrow_out4;

    int checks;
    int errors;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (borrow_out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one start pulse, then wait (bounded) for done; operands are scrambled while busy
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                          output logic [7:0] r_diff, output logic r_bo,
                          output int lat, output int busy_cycles);
        a = op_a;
        b = op_b;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = ~op_a;
        b = ~op_b;
        lat = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
            lat++;
        end
        r_diff = diff;
        r_bo   = borrow_out;
    endtask

    task automatic test_reset_state();
        checks++;
        if ({busy, done, diff, borrow_out} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b diff=%h bo=%b, want all 0",
                     busy, done, diff, borrow_out);
        end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        logic bo;
        int lat, bc;
        run_op(8'd5, 8'd3, d, bo, lat, bc);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d, want 9", lat);
        end
        checks++;
        if (bc !== 8) begin
            errors++;
            $display("[TB] FAIL basic_busy_cycles: got %0d, want 8", bc);
        end
        checks++;
        if ({bo, d} !== {1'b0, 8'd2}) begin
            errors++;
            $display("[TB] FAIL basic_5_minus_3: got diff=%h bo=%b, want diff=02 bo=0", d, bo);
        end
    endtask

    task automatic test_borrow();
        logic [7:0] d;
        logic bo;
        int lat, bc;
        run_op(8'd3, 8'd5, d, bo, lat, bc);
        checks++;
        if ({bo, d} !== {1'b1, 8'hFE}) begin
            errors++;
            $display("[TB] FAIL borrow_3_minus_5: got diff=%h bo=%b, want diff=fe bo=1", d, bo);
        end
        run_op(8'h00, 8'h01, d, bo, lat, bc);
        checks++;
        if ({bo, d} !== {1'b1, 8'hFF}) begin
            errors++;
            $display("[TB] FAIL wrap_0_minus_1: got diff=%h bo=%b, want diff=ff bo=1", d, bo);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] d;
        logic bo;
        int lat, bc;
        run_op(8'd3, 8'd5, d, bo, lat, bc);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, diff, borrow_out} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got busy=%b done=%b diff=%h bo=%b, want all 0",
                     busy, done, diff, borrow_out);
        end
        #1;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if ({done, borrow_out, diff} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL equal_ff_ff: got done=%b diff=%h bo=%b, want done=1 diff=00 bo=0",
                     done, diff, borrow_out);
        end
        a = 8'h80;
        b = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({done, busy} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL b2b_restart: got done=%b busy=%b, want done=0 busy=1", done, busy);
        end
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("[TB] FAIL b2b_latency: got %0d, want 9", lat);
        end
        checks++;
        if ({borrow_out, diff} !== {1'b0, 8'h7F}) begin
            errors++;
            $display("[TB] FAIL b2b_80_minus_01: got diff=%h bo=%b, want diff=7f bo=0",
                     diff, borrow_out);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int pulses;
        logic [7:0] seen;
        pulses = 0;
        seen = 8'hXX;
        a = 8'd5;
        b = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                pulses++;
                seen = diff;
            end
            tick();
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("[TB] FAIL ignore_done_pulses: got %0d, want 1", pulses);
        end
        checks++;
        if (seen !== 8'd2) begin
            errors++;
            $display("[TB] FAIL ignore_result: got diff=%h, want 02", seen);
        end
    endtask

    task automatic test_mid_reset();
        int pulses;
        logic [7:0] d;
        logic bo;
        int lat, bc;
        a = 8'hA5;
        b = 8'h5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, diff, borrow_out} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_clear: got busy=%b done=%b diff=%h bo=%b, want all 0",
                     busy, done, diff, borrow_out);
        end
        #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("[TB] FAIL mid_reset_no_done: got %0d pulses, want 0", pulses);
        end
        run_op(8'hA5, 8'h5A, d, bo, lat, bc);
        checks++;
        if ({bo, d} !== {1'b0, 8'h4B}) begin
            errors++;
            $display("[TB] FAIL restart_a5_minus_5a: got diff=%h bo=%b, want diff=4b bo=0", d, bo);
        end
    endtask

    task automatic test_width4_exhaustive();
        int n;
        logic [3:0] ed;
        logic eb;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                ed = 4'(i - j);
                eb = (i < j);
                a4 = 4'(i);
                b4 = 4'(j);
                start4 = 1'b1;
                tick();
                start4 = 1'b0;
                n = 0;
                while (done4 !== 1'b1 && n < 20) begin
                    tick();
                    n++;
                end
                checks++;
                if ({done4, busy4, borrow_out4, diff4} !== {1'b1, 1'b0, eb, ed}) begin
                    errors++;
                    $display("[TB] FAIL w4_%0d_minus_%0d: got done=%b diff=%h bo=%b, want done=1 diff=%h bo=%b",
                             i, j, done4, diff4, borrow_out4, ed, eb);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        start4 = 1'b0;
        a4 = '0;
        b4 = '0;
        #12;
        test_reset_state();
        rst = 1'b0;
        tick();
        test_basic();
        test_borrow();
        test_async_reset();
        tick();
        test_back_to_back();
        test_ignore_start();
        test_mid_reset();
        tick();
        test_width4_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
